msrv32_branch_predict_unit: RTL

Parametrised successor to the execute-stage branch decision logic. It combines a registered branch-resolution stage, generic in data width, with a table of 2-bit saturating counters. The table is indexed by PC and read at fetch, then trained when a conditional branch resolves. Its outputs are the fetch-stage prediction, plus a registered taken/mispredict verdict that the PC-mux and flush logic consume one cycle after the operands are presented.

---
 rtl/msrv32_pkg.sv | 43 ++++
 rtl/msrv32_branch_cond.sv | 46 ++++
 rtl/msrv32_branch_predict_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared constants and helpers for the msrv32 branch predictor slice.
// Opcodes, funct3 codes, and the 2-bit counter type with its step function.
package msrv32_pkg;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t CTR_SNT = 2'b00;
    localparam bht_ctr_t CTR_WNT = 2'b01;
    localparam bht_ctr_t CTR_WT  = 2'b10;
    localparam bht_ctr_t CTR_ST  = 2'b11;

    // Saturating step of a 2-bit counter toward the resolved outcome.
    function automatic bht_ctr_t ctr_next(input bht_ctr_t c,
                                          input logic taken);
        bht_ctr_t n;
        n = c;
        unique case (c)
            CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
            default: n = c;
        endcase
        return n;
    endfunction

    // funct3 codes that name a real conditional branch.
    function automatic logic f3_valid(input logic [2:0] f3);
        return f3 inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
    endfunction

endpackage

// File: rtl/msrv32_branch_cond.sv
// Combinational branch outcome for JAL/JALR/BRANCH over XLEN-bit operands.
// cond_branch marks a real conditional branch, the only kind that trains.
module msrv32_branch_cond
    import msrv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      opcode,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            cond_branch
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1 == rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));
    assign ltu = (rs1 < rs2);

    // Decode opcode/funct3 into the actual outcome.
    always_comb begin
        taken       = 1'b0;
        cond_branch = 1'b0;
        unique case (opcode)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BRANCH: begin
                cond_branch = f3_valid(funct3);
                unique case (funct3)
                    BEQ:     taken = eq;
                    BNE:     taken = !eq;
                    BLT:     taken = lt;
                    BGE:     taken = !lt;
                    BLTU:    taken = ltu;
                    BGEU:    taken = !ltu;
                    default: taken = 1'b0;
                endcase
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/msrv32_branch_predict_unit.sv
// Branch predictor: PC-indexed 2-bit counter table plus registered verdict.
// Table is built only when MSRV32_BHT_EN is defined; else static not-taken.
module msrv32_branch_predict_unit
    import msrv32_pkg::*;
#(
    parameter int       XLEN      = 32,
    parameter int       BHT_IDX_W = 6,
    parameter bht_ctr_t BHT_INIT  = CTR_WNT
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic [XLEN-1:0] pc_fetch_in,
    output logic            predict_taken_out,
    input  logic            resolve_valid_in,
    input  logic            flush_in,
    input  logic [XLEN-1:0] pc_ex_in,
    input  logic            predicted_taken_ex_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [4:0]      opcode_6_to_2_in,
    input  logic [2:0]      funct3_in,
    output logic            resolved_valid_out,
    output logic            branch_taken_out,
    output logic            mispredict_out
);

    logic taken;
    logic cond_branch;
    logic capture;
    logic unused_bits;

    assign capture = resolve_valid_in & !flush_in;

    msrv32_branch_cond #(
        .XLEN(XLEN)
    ) u_cond (
        .rs1         (rs1_in),
        .rs2         (rs2_in),
        .opcode      (opcode_6_to_2_in),
        .funct3      (funct3_in),
        .taken       (taken),
        .cond_branch (cond_branch)
    );

    // Verdict register: flushed or idle cycles yield an all-zero verdict.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            resolved_valid_out <= 1'b0;
            branch_taken_out   <= 1'b0;
            mispredict_out     <= 1'b0;
        end else begin
            resolved_valid_out <= capture;
            branch_taken_out   <= capture & taken;
            mispredict_out     <= capture & (taken ^ predicted_taken_ex_in);
        end
    end

`ifdef MSRV32_BHT_EN
    localparam int DEPTH = 1 << BHT_IDX_W;

    bht_ctr_t               bht [DEPTH];
    logic [BHT_IDX_W-1:0]   fetch_idx;
    logic [BHT_IDX_W-1:0]   ex_idx;
    logic                   do_train;

    assign fetch_idx = pc_fetch_in[BHT_IDX_W+1:2];
    assign ex_idx    = pc_ex_in[BHT_IDX_W+1:2];
    assign do_train  = capture & cond_branch;

    // Read-before-write: lookup sees the counter value prior to this edge.
    assign predict_taken_out = bht[fetch_idx][1];

    // Counter table: one saturating update per resolved conditional branch.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (do_train) begin
            bht[ex_idx] <= ctr_next(bht[ex_idx], taken);
        end
    end

    assign unused_bits = ^{pc_fetch_in[XLEN-1:BHT_IDX_W+2],
                           pc_fetch_in[1:0],
                           pc_ex_in[XLEN-1:BHT_IDX_W+2],
                           pc_ex_in[1:0]};
`else
    assign predict_taken_out = 1'b0;

    assign unused_bits = ^{pc_fetch_in, pc_ex_in, cond_branch, BHT_INIT};
`endif

endmodule
